// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: PC enable, IF/ID and ID/EX stall/flush,
// EX/MEM freeze, and a sticky data-memory wait timeout.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_W     = 3,
    parameter int unsigned BRANCH_PENALTY = 2,
    parameter int unsigned MAX_WAIT       = 15,
    parameter int unsigned R0_ZERO        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  mem_timeout,
    output logic [1:0]            ctrl_state
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StRedirect = 2'd2
    } state_e;

    localparam logic [2:0] RedirInit = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] MaxWait   = 8'(MAX_WAIT);

    state_e     state_q, state_d;
    logic [2:0] redir_cnt_q, redir_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       resume_redir_q, resume_redir_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       hold;
    logic       load_use;
    logic       rs1_hit, rs2_hit, rd_is_r0;
    logic       waiting;
    logic [7:0] wait_inc;

    assign hold     = dmem_req & ~dmem_ready;
    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign rd_is_r0 = (R0_ZERO != 0) && (ex_rd == '0);
    assign load_use = ex_mem_read & ex_reg_write & (rs1_hit | rs2_hit) & ~rd_is_r0;
    assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            redir_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            resume_redir_q <= 1'b0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            redir_cnt_q    <= redir_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            resume_redir_q <= resume_redir_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        redir_cnt_d    = redir_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        resume_redir_d = resume_redir_q;
        mem_timeout_d  = mem_timeout_q;
        waiting        = 1'b0;
        unique case (state_q)
            StRun: begin
                if (hold) begin
                    state_d        = StMemWait;
                    wait_cnt_d     = 8'd1;
                    resume_redir_d = 1'b0;
                    waiting        = 1'b1;
                end else if (ex_branch_taken && (BRANCH_PENALTY > 1)) begin
                    state_d     = StRedirect;
                    redir_cnt_d = RedirInit;
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d    = resume_redir_q ? StRedirect : StRun;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                    waiting    = 1'b1;
                end
            end
            StRedirect: begin
                if (hold) begin
                    // Remaining flush count is kept and resumed after the wait.
                    state_d        = StMemWait;
                    wait_cnt_d     = 8'd1;
                    resume_redir_d = 1'b1;
                    waiting        = 1'b1;
                end else begin
                    redir_cnt_d = redir_cnt_q - 3'd1;
                    if (redir_cnt_q <= 3'd1) begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StRun;
        endcase
        // Timeout fires on the edge that completes the MAX_WAIT-th wait cycle.
        if (waiting && (wait_cnt_d == MaxWait)) begin
            mem_timeout_d = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        pc_en        = 1'b1;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hold) begin
                        pc_en        = 1'b0;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                StMemWait: begin
                    if (!dmem_ready) begin
                        pc_en        = 1'b0;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end
                end
                StRedirect: begin
                    if (hold) begin
                        pc_en        = 1'b0;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end else begin
                        if_id_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign ctrl_state  = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with default parameters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
    logic       ex_branch_taken, dmem_req, dmem_ready;
    logic       pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic       mem_timeout;
    logic [1:0] ctrl_state;

    int checks   = 0;
    int failures = 0;

    // Output vector: {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
    localparam logic [5:0] ODef = 6'b100000;
    localparam logic [5:0] OFrz = 6'b010101;
    localparam logic [5:0] ORst = 6'b001010;
    localparam logic [5:0] OBr  = 6'b101010;
    localparam logic [5:0] OLu  = 6'b010010;
    localparam logic [5:0] ORed = 6'b101000;

    logic [5:0] outs;
    assign outs = {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

    hazard_ctrl #(
        .REG_ADDR_W    (3),
        .BRANCH_PENALTY(2),
        .MAX_WAIT      (15),
        .R0_ZERO       (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_reg_write   (ex_reg_write),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_en          (pc_en),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_stall    (id_ex_stall),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_stall   (ex_mem_stall),
        .mem_timeout    (mem_timeout),
        .ctrl_state     (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance past the next edge; inputs are driven, then outputs sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_reg_write = 0;
        ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;

        // Reset
        step(); settle();
        chk("rst_outs", {2'b0, outs}, {2'b0, ORst});
        step(); rst = 1'b0; settle();
        chk("post_rst_state", {6'b0, ctrl_state}, 8'd0);
        chk("post_rst_timeout", {7'b0, mem_timeout}, 8'd0);
        chk("post_rst_outs", {2'b0, outs}, {2'b0, ODef});

        // Load-use on rs2
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1; settle();
        chk("lu_rs2", {2'b0, outs}, {2'b0, OLu});
        step(); ex_mem_read = 0; settle();
        chk("lu_bubble_clears", {2'b0, outs}, {2'b0, ODef});
        chk("lu_state", {6'b0, ctrl_state}, 8'd0);
        // Load-use on rs1
        ex_mem_read = 1; id_use_rs2 = 0; id_use_rs1 = 1; id_rs1 = 5; ex_rd = 5; settle();
        chk("lu_rs1", {2'b0, outs}, {2'b0, OLu});
        // r0 destination never stalls
        step(); id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 0; ex_rd = 0; settle();
        chk("lu_r0", {2'b0, outs}, {2'b0, ODef});
        // match but rs2 unused
        step(); id_use_rs2 = 0; id_rs2 = 3; ex_rd = 3; settle();
        chk("lu_unused", {2'b0, outs}, {2'b0, ODef});
        // match but EX does not write
        step(); id_use_rs2 = 1; ex_reg_write = 0; settle();
        chk("lu_no_write", {2'b0, outs}, {2'b0, ODef});
        step(); ex_mem_read = 0; id_use_rs2 = 0; settle();

        // Taken branch, penalty 2
        ex_branch_taken = 1; settle();
        chk("br_c0_outs", {2'b0, outs}, {2'b0, OBr});
        step(); ex_branch_taken = 0; settle();
        chk("br_c1_outs", {2'b0, outs}, {2'b0, ORed});
        chk("br_c1_state", {6'b0, ctrl_state}, 8'd2);
        step(); settle();
        chk("br_c2_state", {6'b0, ctrl_state}, 8'd0);
        chk("br_c2_outs", {2'b0, outs}, {2'b0, ODef});

        // Memory wait: 4 cycles then ready
        dmem_req = 1; dmem_ready = 0; settle();
        chk("mw_c1_outs", {2'b0, outs}, {2'b0, OFrz});
        for (int k = 2; k <= 4; k++) begin
            step(); settle();
            chk("mw_freeze_outs", {2'b0, outs}, {2'b0, OFrz});
            chk("mw_freeze_state", {6'b0, ctrl_state}, 8'd1);
        end
        step(); dmem_ready = 1; settle();
        chk("mw_release_outs", {2'b0, outs}, {2'b0, ODef});
        step(); dmem_req = 0; dmem_ready = 0; settle();
        chk("mw_after_state", {6'b0, ctrl_state}, 8'd0);
        chk("mw_no_timeout", {7'b0, mem_timeout}, 8'd0);

        // Timeout: 20 wait cycles
        dmem_req = 1; dmem_ready = 0;
        for (int k = 1; k <= 20; k++) begin
            settle();
            if (k == 1 || k == 20) chk("to_freeze", {2'b0, outs}, {2'b0, OFrz});
            step();
            if (k == 14) chk("to_not_yet", {7'b0, mem_timeout}, 8'd0);
            if (k == 15) chk("to_raised", {7'b0, mem_timeout}, 8'd1);
        end
        dmem_ready = 1; settle();
        chk("to_release_outs", {2'b0, outs}, {2'b0, ODef});
        step(); dmem_req = 0; dmem_ready = 0; settle();
        chk("to_sticky", {7'b0, mem_timeout}, 8'd1);
        chk("to_state_run", {6'b0, ctrl_state}, 8'd0);
        rst = 1; settle();
        chk("to_rst_outs", {2'b0, outs}, {2'b0, ORst});
        step(); rst = 0; settle();
        chk("to_cleared", {7'b0, mem_timeout}, 8'd0);

        // Hold together with taken branch: freeze wins, flush after release
        dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1; settle();
        chk("hb_freeze", {2'b0, outs}, {2'b0, OFrz});
        step(); settle();
        chk("hb_wait_state", {6'b0, ctrl_state}, 8'd1);
        step(); dmem_ready = 1; settle();
        chk("hb_release", {2'b0, outs}, {2'b0, ODef});
        step(); dmem_req = 0; dmem_ready = 0; settle();
        chk("hb_flush", {2'b0, outs}, {2'b0, OBr});
        step(); ex_branch_taken = 0; settle();
        chk("hb_redirect", {2'b0, outs}, {2'b0, ORed});
        step(); settle();
        chk("hb_done", {6'b0, ctrl_state}, 8'd0);

        // Hold during REDIRECT with one flush remaining
        ex_branch_taken = 1; settle();
        chk("hr_branch", {2'b0, outs}, {2'b0, OBr});
        step(); ex_branch_taken = 0; dmem_req = 1; dmem_ready = 0; settle();
        chk("hr_freeze_noflush", {2'b0, outs}, {2'b0, OFrz});
        step(); settle();
        chk("hr_wait_state", {6'b0, ctrl_state}, 8'd1);
        step(); dmem_ready = 1; settle();
        chk("hr_release", {2'b0, outs}, {2'b0, ODef});
        step(); dmem_req = 0; dmem_ready = 0; settle();
        chk("hr_resume_state", {6'b0, ctrl_state}, 8'd2);
        chk("hr_resume_flush", {2'b0, outs}, {2'b0, ORed});
        step(); settle();
        chk("hr_back_run", {6'b0, ctrl_state}, 8'd0);

        // Reset in the middle of MEM_WAIT
        dmem_req = 1; dmem_ready = 0; settle();
        step(); settle();
        chk("rm_in_wait", {6'b0, ctrl_state}, 8'd1);
        rst = 1; settle();
        chk("rm_rst_outs", {2'b0, outs}, {2'b0, ORst});
        step(); rst = 0; dmem_req = 0; settle();
        chk("rm_state", {6'b0, ctrl_state}, 8'd0);
        chk("rm_timeout", {7'b0, mem_timeout}, 8'd0);
        chk("rm_outs", {2'b0, outs}, {2'b0, ODef});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
